aud_player_i2s: RTL and testbench
=================================

# aud_player_i2s

Parametrised stereo serializer for the WM8731 DAC path, driven by the codec bit clock. It accepts one stereo frame at a time over a ready/valid handshake and double-buffers it. It shifts left and right samples MSB-first onto DACDAT, aligned to DACLRCK, in I2S or left-justified mode, and signals underrun when no frame is pending at frame start. It sits between the playback sample source (SRAM reader / rate converter) and the codec pins, and replaces the fixed 16-bit mono-word player.

## Interface
- DATA_W, 16, sample width per channel (8..32)
- CNT_W, 6, bit-position counter width; must satisfy 2^CNT_W > DATA_W
- i_clk  in  1  AUD_BCLK; all logic on posedge
- i_rst_n  in  1  reset; **one clock; reset is synchronous and active-low** (sampled on posedge i_clk)
- i_lrc  in  1  AUD_DACLRCK; low = left half-frame, high = right
- i_en  in  1  play enable (high = play, low = pause)
- i_mode  in  1  0 = I2S (MSB one BCLK after LRC edge), 1 = left-justified
- i_valid  in  1  frame valid
- i_data_l  in  DATA_W  left sample, two's complement
- i_data_r  in  DATA_W  right sample
- o_ready  out  1  pending buffer empty
- o_aud_dacdat  out  1  serial data to codec
- o_underrun  out  1  one-cycle pulse on frame-start underrun
- o_underrun_cnt  out  16  underrun count (present only with AUD_PLAYER_UNDERRUN_CNT_EN)

## Operation
- lrc_r registers i_lrc every cycle; it resets to 0.
- Rising edge: lrc_r=0 and i_lrc=1.
- Falling edge: lrc_r=1 and i_lrc=0.
- Frame start (FS) = falling edge.
- Pending buffer: holds one stereo frame plus pend_vld.
- o_ready = !pend_vld, registered.
- Transfer occurs when i_valid && o_ready on a posedge. The buffer then holds the frame, and o_ready drops on the next cycle.
- States:
  - IDLE (reset): output 0. Goes to PLAY at FS if i_en=1; otherwise stays.
  - PLAY: serializes. Goes to PAUSE at FS if i_en=0.
  - PAUSE: output 0 and buffer retained. Goes to PLAY at FS if i_en=1.
- i_en is evaluated only at FS, so a frame in flight always completes.
- At FS entering or staying in PLAY:
  - If pend_vld=1: left shift reg <= pending L, right hold reg <= pending R, pend_vld <= 0.
  - If pend_vld=0: both regs <= 0, and o_underrun pulses for 1 cycle.
- i_mode is latched at FS and is constant within a frame.
- Per half-frame (left after FS, right after rising edge): bit counter loads at the edge and serializes DATA_W bits MSB-first. Output is 0 after the LSB until the next edge.
- Short half-frame (next edge arrives before the LSB): truncate and restart on the new channel.
- Simultaneous FS and transfer with pend_vld=0: underrun counted, zeros played, and the incoming frame is stored as pending (no bypass).

## Timing
- Edge cycle E = the posedge at which the edge is detected.
- Left-justified: MSB appears on o_aud_dacdat after E (registered at E), LSB after E+DATA_W-1.
- I2S: MSB appears after E+1, LSB after E+DATA_W.
- Handshake latency: a frame accepted at cycle T plays from the next FS after T.
- Reset values:
  - o_aud_dacdat=0, o_ready=1, o_underrun=0, o_underrun_cnt=0
  - state=IDLE, pend_vld=0, lrc_r=0
- Reset mid-frame: the output returns to 0 on the next cycle, the pending frame is discarded, and playback waits for a genuine falling edge.
- Reset is synchronous: it takes effect only on posedge i_clk.

## Configuration
- AUD_PLAYER_UNDERRUN_CNT_EN defined: port o_underrun_cnt exists.
  - Increments on each o_underrun pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- AUD_PLAYER_UNDERRUN_CNT_EN undefined: the port and counter are absent. The o_underrun pulse is unchanged.

## Test plan
- DATA_W=16, I2S, LRC period 64 BCLK (32/32), L=16'hA5C3, R=16'h0F0F loaded before FS -> bits of A5C3 MSB-first on cycles E+1..E+16, zeros to E+31; 0F0F after the rising edge in the same pattern.
- Same frame, i_mode=1 -> every bit one cycle earlier than the I2S case (MSB after E).
- No frame supplied before FS in PLAY -> zeros for the whole frame, o_underrun=1 for exactly one cycle at E, o_underrun_cnt=1 (macro on); a frame supplied at E is played at the following FS.
- i_en dropped mid-left-half -> the current frame completes both channels; the next frame is 0, pend_vld stays 1 and o_ready stays 0; i_en raised -> the pending frame plays at the next FS.
- DATA_W=24, LRC half-frame 16 BCLK -> 16 MSBs output then truncated; the right channel starts cleanly at the rising edge.
- i_rst_n low for 1 cycle mid-right-half with a pending frame -> o_aud_dacdat=0, o_ready=1 next cycle, IDLE until the next falling edge.

Source files
------------

// File: rtl/aud_player_i2s.sv
// aud_player_i2s: double-buffered stereo serializer for the WM8731 DAC path.
// All logic runs on AUD_BCLK. A frame is accepted over valid/ready into a
// pending buffer and starts playing at the next LRC falling edge (frame start).
// Samples are shifted MSB-first in I2S (one BCLK delay) or left-justified mode.
// Optional feature macro: AUD_PLAYER_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun counter on port o_underrun_cnt.
module aud_player_i2s #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lrc,
   input  logic              i_en,
   input  logic              i_mode,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data_l,
   input  logic [DATA_W-1:0] i_data_r,
   output logic              o_ready,
   output logic              o_aud_dacdat,
   output logic              o_underrun
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       o_underrun_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t              state;
   logic                lrc_r;
   logic                pend_vld;
   logic [DATA_W-1:0]   pend_l;
   logic [DATA_W-1:0]   pend_r;
   logic [DATA_W-1:0]   shift_reg;
   logic [DATA_W-1:0]   hold_r;
   logic [CNT_W-1:0]    bit_cnt;
   logic                mode_r;

   logic                lrc_rise;
   logic                lrc_fall;
   logic                take;
   logic                frame_load;
   logic                underrun_evt;
   logic [DATA_W-1:0]   left_word;
   logic [DATA_W-1:0]   ld_word;
   logic                ld_mode;

   // Edge detection, handshake and the word/mode selected for a channel load.
   always_comb begin
      lrc_rise     = 1'b0;
      lrc_fall     = 1'b0;
      take         = 1'b0;
      frame_load   = 1'b0;
      underrun_evt = 1'b0;
      left_word    = '0;
      ld_word      = '0;
      ld_mode      = 1'b0;
      lrc_rise     = !lrc_r && i_lrc;
      lrc_fall     = lrc_r && !i_lrc;
      take         = i_valid && o_ready;
      // i_en is only looked at on frame start so a frame in flight completes
      frame_load   = lrc_fall && i_en;
      underrun_evt = frame_load && !pend_vld;
      if (pend_vld) begin
         left_word = pend_l;
      end else begin
         left_word = '0;
      end
      if (lrc_fall) begin
         ld_word = left_word;
         ld_mode = i_mode;
      end else begin
         ld_word = hold_r;
         ld_mode = mode_r;
      end
   end

   // Delayed copy of LRC for edge detection.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         lrc_r <= 1'b0;
      end else begin
         lrc_r <= i_lrc;
      end
   end

   // Pending frame buffer; an arriving frame is never bypassed to the shifter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pend_vld <= 1'b0;
         pend_l   <= '0;
         pend_r   <= '0;
         o_ready  <= 1'b1;
      end else if (take) begin
         pend_vld <= 1'b1;
         pend_l   <= i_data_l;
         pend_r   <= i_data_r;
         o_ready  <= 1'b0;
      end else if (frame_load && pend_vld) begin
         pend_vld <= 1'b0;
         o_ready  <= 1'b1;
      end else begin
         pend_vld <= pend_vld;
         o_ready  <= !pend_vld;
      end
   end

   // Playback FSM and serializer with registered data and underrun outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         o_aud_dacdat <= 1'b0;
         o_underrun   <= 1'b0;
         shift_reg    <= '0;
         hold_r       <= '0;
         bit_cnt      <= '0;
         mode_r       <= 1'b0;
      end else begin
         o_underrun <= 1'b0;
         if (lrc_fall) begin
            mode_r <= i_mode;
         end else begin
            mode_r <= mode_r;
         end
         if (lrc_fall && !i_en) begin
            // frame start while disabled: IDLE stays IDLE, PLAY parks in PAUSE
            case (state)
               ST_IDLE: state <= ST_IDLE;
               default: state <= ST_PAUSE;
            endcase
            o_aud_dacdat <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
         end else if (frame_load || (lrc_rise && (state == ST_PLAY))) begin
            if (frame_load) begin
               state      <= ST_PLAY;
               o_underrun <= !pend_vld;
               if (pend_vld) begin
                  hold_r <= pend_r;
               end else begin
                  hold_r <= '0;
               end
            end else begin
               state <= state;
            end
            // left-justified drives the MSB right away, I2S one BCLK later
            if (ld_mode) begin
               o_aud_dacdat <= ld_word[DATA_W-1];
               shift_reg    <= {ld_word[DATA_W-2:0], 1'b0};
               bit_cnt      <= CNT_W'(DATA_W - 1);
            end else begin
               o_aud_dacdat <= 1'b0;
               shift_reg    <= ld_word;
               bit_cnt      <= CNT_W'(DATA_W);
            end
         end else if ((state == ST_PLAY) && (bit_cnt != {CNT_W{1'b0}})) begin
            o_aud_dacdat <= shift_reg[DATA_W-1];
            shift_reg    <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt      <= bit_cnt - CNT_W'(1);
         end else begin
            // after the LSB, or while not playing, the line idles low
            o_aud_dacdat <= 1'b0;
            bit_cnt      <= '0;
         end
      end
   end

`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
   // Saturating count of frame-start underruns, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_underrun_cnt <= 16'h0000;
      end else if (underrun_evt && (o_underrun_cnt != 16'hFFFF)) begin
         o_underrun_cnt <= o_underrun_cnt + 16'h0001;
      end else begin
         o_underrun_cnt <= o_underrun_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_aud_player_i2s.sv
// Self-checking bench for aud_player_i2s: table of frames driven against a
// 16-bit instance with a scoreboard queue of expected serial bits, plus a
// hand-written truncation sequence on a 24-bit instance.
`timescale 1ns/1ps
module tb_aud_player_i2s;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 16-bit instance
   logic        rst_n, lrc, en, mode, valid;
   logic [15:0] dl, dr;
   logic        ready, dacdat, und;
   // 24-bit instance
   logic        rst2, lrc2, en2, mode2, valid2;
   logic [23:0] dl2, dr2;
   logic        ready2, dacdat2, und2;
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
   logic [15:0] ucnt, ucnt2;
`endif

   aud_player_i2s #(.DATA_W(16), .CNT_W(6)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_en(en), .i_mode(mode),
      .i_valid(valid), .i_data_l(dl), .i_data_r(dr),
      .o_ready(ready), .o_aud_dacdat(dacdat), .o_underrun(und)
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
      , .o_underrun_cnt(ucnt)
`endif
   );

   aud_player_i2s #(.DATA_W(24), .CNT_W(6)) dut24 (
      .i_clk(clk), .i_rst_n(rst2), .i_lrc(lrc2), .i_en(en2), .i_mode(mode2),
      .i_valid(valid2), .i_data_l(dl2), .i_data_r(dr2),
      .o_ready(ready2), .o_aud_dacdat(dacdat2), .o_underrun(und2)
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
      , .o_underrun_cnt(ucnt2)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic dat;
      logic und;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic        en;       // i_en applied mid-left half, used at next frame start
      logic        mode;     // i_mode at frame start (inverted during right half)
      int          give_at;  // cycle of the frame at which a frame is offered, -1 none
      logic [15:0] gl;
      logic [15:0] gr;
      int          rst_at;   // cycle of a one-cycle reset, -1 none
   } vec_t;
   vec_t vecs[12];

   // reference model state
   logic        m_pend;
   logic [15:0] m_pl, m_pr;
   int          m_cnt;

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected serial bit k cycles after the edge cycle for a w-bit word.
   function automatic logic exp_bit(input logic [31:0] word, input int w, input logic lj, input int k);
      if (lj) begin
         if (k < w) return word[w-1-k];
         return 1'b0;
      end
      if (k >= 1 && k <= w) return word[w-k];
      return 1'b0;
   endfunction

   task automatic run_frame(input int fi, input vec_t v);
      logic        rdy_before;
      logic [15:0] L, R;
      logic        u;
      exp_t        e;
      for (int j = 0; j < 64; j++) begin
         lrc   = (j < 32) ? 1'b0 : 1'b1;
         if (j == 0)  mode = v.mode;
         if (j == 33) mode = ~v.mode;
         if (j == 10) en = v.en;
         valid = (j == v.give_at);
         dl    = v.gl;
         dr    = v.gr;
         rst_n = (j == v.rst_at) ? 1'b0 : 1'b1;
         if (j == v.rst_at) begin
            m_pend = 1'b0;
            m_cnt  = 0;
            sbq.delete();
            for (int k = j; k < 64; k++) sbq.push_back('{dat: 1'b0, und: 1'b0});
         end else begin
            rdy_before = !m_pend;
            if (j == 0) begin
               if (en) begin
                  if (m_pend) begin
                     L = m_pl; R = m_pr; u = 1'b0; m_pend = 1'b0;
                  end else begin
                     L = 16'h0; R = 16'h0; u = 1'b1;
                     if (m_cnt < 65535) m_cnt++;
                  end
                  for (int k = 0; k < 64; k++) begin
                     if (k < 32) sbq.push_back('{dat: exp_bit({16'h0, L}, 16, v.mode, k), und: (k == 0) && u});
                     else        sbq.push_back('{dat: exp_bit({16'h0, R}, 16, v.mode, k - 32), und: 1'b0});
                  end
               end else begin
                  for (int k = 0; k < 64; k++) sbq.push_back('{dat: 1'b0, und: 1'b0});
               end
            end
            if (valid && rdy_before) begin
               m_pend = 1'b1; m_pl = dl; m_pr = dr;
            end
         end
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            check1($sformatf("f%0d c%0d scoreboard empty", fi, j), 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check1($sformatf("f%0d c%0d dacdat", fi, j), {31'd0, dacdat}, {31'd0, e.dat});
            check1($sformatf("f%0d c%0d underrun", fi, j), {31'd0, und}, {31'd0, e.und});
         end
         check1($sformatf("f%0d c%0d ready", fi, j), {31'd0, ready}, {31'd0, !m_pend});
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
         if (j == 63) check1($sformatf("f%0d underrun_cnt", fi), {16'd0, ucnt}, m_cnt);
`endif
      end
   endtask

   initial begin
      logic [23:0] wl, wr;
      logic        lj;
      rst_n = 1'b0; lrc = 1'b1; en = 1'b1; mode = 1'b0; valid = 1'b0; dl = '0; dr = '0;
      rst2 = 1'b0; lrc2 = 1'b1; en2 = 1'b1; mode2 = 1'b0; valid2 = 1'b0; dl2 = '0; dr2 = '0;
      m_pend = 1'b0; m_pl = '0; m_pr = '0; m_cnt = 0;

      vecs[0]  = '{1'b1, 1'b0, 40, 16'hA5C3, 16'h0F0F, -1};
      vecs[1]  = '{1'b1, 1'b1, -1, 16'h0000, 16'h0000, -1};
      vecs[2]  = '{1'b1, 1'b0,  0, 16'h5A5A, 16'hC33C, -1};
      vecs[3]  = '{1'b1, 1'b0, 40, 16'h1357, 16'h9BDF, -1};
      vecs[4]  = '{1'b0, 1'b1, 40, 16'hFFFF, 16'h0001, -1};
      vecs[5]  = '{1'b1, 1'b0, 40, 16'h1111, 16'h2222, -1};
      vecs[6]  = '{1'b1, 1'b1, 40, 16'h8000, 16'h7FFF, -1};
      vecs[7]  = '{1'b1, 1'b0, -1, 16'h0000, 16'h0000, -1};
      vecs[8]  = '{1'b1, 1'b1, 40, 16'h2468, 16'hACE0, -1};
      vecs[9]  = '{1'b1, 1'b0, 20, 16'hDEAD, 16'hBEEF, 40};
      vecs[10] = '{1'b1, 1'b1, 40, 16'h0F0F, 16'hA5C3, -1};
      vecs[11] = '{1'b1, 1'b0, -1, 16'h0000, 16'h0000, -1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check1("reset dacdat", {31'd0, dacdat}, 32'd0);
      check1("reset ready", {31'd0, ready}, 32'd1);
      check1("reset underrun", {31'd0, und}, 32'd0);
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
      check1("reset underrun_cnt", {16'd0, ucnt}, 32'd0);
`endif

      // idle with LRC high: load the first frame, output stays low
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         valid = (c == 2);
         dl = 16'hA5C3; dr = 16'h0F0F;
         @(posedge clk); #1;
         check1($sformatf("idle c%0d dacdat", c), {31'd0, dacdat}, 32'd0);
         check1($sformatf("idle c%0d ready", c), {31'd0, ready}, (c < 2) ? 32'd1 : 32'd0);
      end
      valid = 1'b0;
      m_pend = 1'b1; m_pl = 16'hA5C3; m_pr = 16'h0F0F;

      for (int f = 0; f < 12; f++) run_frame(f, vecs[f]);

      // 24-bit samples with 16-BCLK half-frames: truncation and clean restart
      rst2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst2 = 1'b1; valid2 = 1'b1; dl2 = 24'hABCDEF; dr2 = 24'h123456;
      @(posedge clk); #1;
      valid2 = 1'b0;
      check1("w24 ready after load", {31'd0, ready2}, 32'd0);
      for (int f = 0; f < 2; f++) begin
         lj = (f == 0);
         wl = (f == 0) ? 24'hABCDEF : 24'hFEDCBA;
         wr = (f == 0) ? 24'h123456 : 24'h654321;
         for (int j = 0; j < 32; j++) begin
            lrc2   = (j < 16) ? 1'b0 : 1'b1;
            mode2  = (j == 0) ? lj : ~lj;
            valid2 = (f == 0) && (j == 20);
            dl2    = 24'hFEDCBA; dr2 = 24'h654321;
            @(posedge clk); #1;
            check1($sformatf("w24 f%0d c%0d dacdat", f, j), {31'd0, dacdat2},
                   {31'd0, (j < 16) ? exp_bit({8'h0, wl}, 24, lj, j) : exp_bit({8'h0, wr}, 24, lj, j - 16)});
            if (j == 0) check1($sformatf("w24 f%0d underrun", f), {31'd0, und2}, 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
